// File: rtl/mips_trace_pkg.sv
// Shared encodings for the pipeline trace buffer: FSM states and capture modes.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_TRIG    = 2'b10;
  localparam logic [1:0] MODE_CHANGE  = 2'b11;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port, no reset.
module trace_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 144
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Read-before-write on an address collision falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Capture engine for MIPS pipeline debug probes: circular buffer with timestamps and
// free-run, one-shot, trigger+post and change-only modes.
module pipeline_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned TSW   = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            arm,
  input  logic [1:0]      mode,
  input  logic [AW:0]     post_count,
  input  logic [CH*W-1:0] probe,
  input  logic            probe_valid,
  input  logic            trig,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_idx,
  output logic [CH*W-1:0] rd_data,
  output logic [TSW-1:0]  rd_ts,
  output logic            rd_valid,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic            overflow
);

  localparam int unsigned PW   = CH * W;
  localparam int unsigned DW   = PW + TSW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  trace_state_e  state_q, state_d;
  logic [1:0]    mode_q;
  logic [AW:0]   post_q;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] wptr_q;
  logic [TSW-1:0] ts_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic [PW-1:0] last_q;
  logic          hist_q;
  logic          rd_valid_q;
  logic          rd_hit_q;

  logic          capturing;
  logic          changed;
  logic          we;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_addr;
  logic          rd_in_range;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    capturing = (state_q == CAPTURE) || (state_q == POST);
    changed   = !hist_q || (probe != last_q);
    // arm wins over a same-cycle sample.
    we        = capturing && enable && probe_valid && !arm &&
                ((mode_q != MODE_CHANGE) || changed);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (arm) begin
      state_d = CAPTURE;
    end else begin
      unique case (state_q)
        CAPTURE: begin
          if (mode_q == MODE_ONESHOT && we && count_q == LAST) begin
            state_d = DONE;
          end else if (mode_q == MODE_TRIG && enable && trig) begin
            rem_d   = post_q;
            state_d = (post_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          // The trigger-cycle write happens in CAPTURE, so it never decrements here.
          if (we) begin
            rem_d = rem_q - ONE;
            if (rem_q == ONE) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_FREE;
      post_q     <= '0;
      rem_q      <= '0;
      wptr_q     <= '0;
      ts_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
      hist_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (arm) begin
        mode_q     <= mode;
        post_q     <= post_count;
        wptr_q     <= '0;
        ts_q       <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        hist_q     <= 1'b0;
      end else begin
        if (capturing && enable) ts_q <= ts_q + 1'b1;
        if (we) begin
          wptr_q <= wptr_q + 1'b1;
          last_q <= probe;
          hist_q <= 1'b1;
          if (count_q == FULL) overflow_q <= 1'b1;
          else                 count_q    <= count_q + ONE;
        end
      end
    end
  end

  // Oldest entry sits at the write pointer once the buffer has wrapped.
  always_comb begin
    rd_base     = (count_q < FULL) ? '0 : wptr_q;
    rd_addr     = rd_base + rd_idx;
    rd_in_range = {1'b0, rd_idx} < count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_hit_q <= rd_in_range;
    end
  end

  trace_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata ({probe, ts_q}),
    .re    (rd_req),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_data  = rd_hit_q ? ram_rdata[DW-1:TSW] : '0;
  assign rd_ts    = rd_hit_q ? ram_rdata[TSW-1:0]  : '0;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer: directed scenarios plus randomized
// traffic, compared against a queue-based reference model.
module tb_pipeline_trace_buffer;

  localparam int unsigned CH = 2, W = 32, DEPTH = 8, TSW = 16, AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable = 1'b0, arm = 1'b0, probe_valid = 1'b0, trig = 1'b0, rd_req = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW:0]   post_count = '0;
  logic [63:0]   probe = '0;
  logic [AW-1:0] rd_idx = '0;
  logic [63:0]   rd_data;
  logic [15:0]   rd_ts;
  logic          rd_valid;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: logical list of valid entries, oldest first.
  int          m_state, m_mode, m_post, m_rem, m_ts;
  bit          m_ovf, m_hist;
  logic [63:0] m_last;
  logic [63:0] mq[$];
  logic [15:0] tq[$];

  pipeline_trace_buffer #(
    .CH    (CH),
    .W     (W),
    .DEPTH (DEPTH),
    .TSW   (TSW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .arm         (arm),
    .mode        (mode),
    .post_count  (post_count),
    .probe       (probe),
    .probe_valid (probe_valid),
    .trig        (trig),
    .rd_req      (rd_req),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .rd_ts       (rd_ts),
    .rd_valid    (rd_valid),
    .state       (state),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_post = 0; m_rem = 0; m_ts = 0;
    m_ovf = 0; m_hist = 0; m_last = '0;
    mq.delete(); tq.delete();
  endtask

  task automatic model_read(input int idx, output logic [63:0] d, output logic [15:0] t);
    if (idx < mq.size()) begin d = mq[idx]; t = tq[idx]; end
    else begin d = '0; t = '0; end
  endtask

  task automatic model_step();
    int ns;
    bit cap, wr;
    if (arm) begin
      mq.delete(); tq.delete();
      m_state = 1; m_ovf = 0; m_ts = 0; m_hist = 0;
      m_mode = int'(mode); m_post = int'(post_count);
      return;
    end
    cap = (m_state == 1) || (m_state == 2);
    wr  = cap && enable && probe_valid && (m_mode != 3 || !m_hist || probe != m_last);
    ns  = m_state;
    if (m_state == 1 && m_mode == 2 && enable && trig) begin
      m_rem = m_post;
      ns = (m_post == 0) ? 3 : 2;
    end
    if (wr) begin
      if (m_state == 1 && m_mode == 1 && mq.size() == DEPTH - 1) ns = 3;
      mq.push_back(probe);
      tq.push_back(16'(m_ts));
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        void'(tq.pop_front());
        m_ovf = 1;
      end
      m_last = probe;
      m_hist = 1;
      if (m_state == 2) begin
        m_rem--;
        if (m_rem == 0) ns = 3;
      end
    end
    if (cap && enable) m_ts = (m_ts + 1) % 65536;
    m_state = ns;
  endtask

  // One clock: compute expected read before the edge, advance model, check after the edge.
  task automatic cycle();
    logic [63:0] ed;
    logic [15:0] et;
    logic        rq;
    rq = rd_req;
    if (rq) model_read(int'(rd_idx), ed, et);
    @(posedge clk);
    model_step();
    #1;
    check("state", 64'(state), 64'(m_state));
    check("count", 64'(count), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("rd_valid", 64'(rd_valid), 64'(rq));
    if (rq) begin
      check("rd_data", rd_data, ed);
      check("rd_ts", 64'(rd_ts), 64'(et));
    end
    arm = 1'b0; trig = 1'b0; rd_req = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] md, input logic [AW:0] pc);
    mode = md; post_count = pc; arm = 1'b1; probe_valid = 1'b0;
    cycle();
  endtask

  task automatic read_at(input int idx);
    rd_req = 1'b1; rd_idx = AW'(idx); probe_valid = 1'b0;
    cycle();
  endtask

  initial begin
    logic [63:0] a_val, b_val;
    model_reset();
    reset = 1'b1;
    #3;
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_rd_ts", 64'(rd_ts), 64'd0);
    #9 reset = 1'b0;

    // Idle: samples without arm are ignored.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin probe = 64'(i + 50); probe_valid = 1'b1; cycle(); end
    check("idle_count", 64'(count), 64'd0);
    read_at(0);
    check("idle_rd_data", rd_data, 64'd0);

    // Free-run wrap.
    do_arm(2'b00, '0);
    for (int i = 1; i <= 11; i++) begin probe = 64'(i); probe_valid = 1'b1; cycle(); end
    check("free_count", 64'(count), 64'd8);
    check("free_overflow", 64'(overflow), 64'd1);
    for (int k = 0; k < 8; k++) begin
      read_at(k);
      check("free_entry", rd_data, 64'(k + 4));
      check("free_ts", 64'(rd_ts), 64'(k + 3));
    end

    // One-shot.
    do_arm(2'b01, '0);
    for (int i = 1; i <= 10; i++) begin probe = 64'(i); probe_valid = 1'b1; cycle(); end
    check("oneshot_state", 64'(state), 64'd3);
    for (int k = 0; k < 8; k++) begin read_at(k); check("oneshot_entry", rd_data, 64'(k + 1)); end

    // Trigger with 3 post samples.
    do_arm(2'b10, 4'd3);
    for (int i = 1; i <= 12; i++) begin
      probe = 64'(i); probe_valid = 1'b1; trig = (i == 5);
      cycle();
    end
    check("trig_state", 64'(state), 64'd3);
    read_at(7);
    check("trig_last_entry", rd_data, 64'd8);

    // Change-only.
    a_val = 64'h0000_AAAA_0000_AAAA;
    b_val = 64'h0000_BBBB_0000_BBBB;
    do_arm(2'b11, '0);
    for (int i = 0; i < 6; i++) begin
      probe = (i == 3 || i == 4) ? b_val : a_val; probe_valid = 1'b1; cycle();
    end
    check("change_count", 64'(count), 64'd3);
    read_at(0); check("change_e0", rd_data, a_val); check("change_t0", 64'(rd_ts), 64'd0);
    read_at(1); check("change_e1", rd_data, b_val); check("change_t1", 64'(rd_ts), 64'd3);
    read_at(2); check("change_e2", rd_data, a_val); check("change_t2", 64'(rd_ts), 64'd5);

    // Full buffer, trigger-cycle write collides with a read of the oldest entry, then re-arm.
    do_arm(2'b10, 4'd15);
    for (int i = 1; i <= 10; i++) begin probe = 64'(100 + i); probe_valid = 1'b1; cycle(); end
    probe = 64'd200; probe_valid = 1'b1; trig = 1'b1; rd_req = 1'b1; rd_idx = '0;
    cycle();
    check("collide_old_data", rd_data, 64'd103);
    check("collide_post", 64'(state), 64'd2);
    probe = 64'd201; probe_valid = 1'b1; cycle();
    probe = 64'd202; probe_valid = 1'b1; arm = 1'b1; mode = 2'b00; cycle();
    check("rearm_count", 64'(count), 64'd0);
    check("rearm_state", 64'(state), 64'd1);
    check("rearm_overflow", 64'(overflow), 64'd0);

    // Randomized traffic; mode/post_count wander between arms to exercise latching.
    for (int ep = 0; ep < 30; ep++) begin
      do_arm(2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)));
      for (int c = 0; c < 40; c++) begin
        mode        = 2'($urandom_range(0, 3));
        post_count  = 4'($urandom_range(0, 15));
        enable      = ($urandom_range(0, 99) < 85);
        probe_valid = ($urandom_range(0, 99) < 75);
        probe       = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3))
                                                  : {$urandom, $urandom};
        trig        = ($urandom_range(0, 99) < 10);
        rd_req      = ($urandom_range(0, 99) < 40);
        rd_idx      = AW'($urandom_range(0, 7));
        arm         = ($urandom_range(0, 99) < 3);
        cycle();
      end
    end

    // Asynchronous reset mid-capture drops an in-flight read response.
    enable = 1'b1;
    do_arm(2'b00, '0);
    for (int i = 1; i <= 3; i++) begin probe = 64'(i + 7); probe_valid = 1'b1; cycle(); end
    read_at(0);
    check("pre_reset_data", rd_data, 64'd8);
    reset = 1'b1;
    #1;
    check("async_state", 64'(state), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_overflow", 64'(overflow), 64'd0);
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rd_data", rd_data, 64'd0);
    check("async_rd_ts", 64'(rd_ts), 64'd0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin probe_valid = 1'b1; cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
